// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide unit bundle. Handshake: an op is accepted on a rising edge in
// IDLE with StartE=1 and FlushE=0; execute holds the op while StallMD=1 and takes the result when MDValidE=1.
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  StartE;
  logic [2:0]            MulDivOpE;
  logic [DATA_WIDTH-1:0] SrcAE;
  logic [DATA_WIDTH-1:0] SrcBE;
  logic [ADDR_WIDTH-1:0] RdE;
  logic                  FlushE;
  logic                  StallMD;
  logic                  MDValidE;
  logic [DATA_WIDTH-1:0] MDResultE;
  logic [ADDR_WIDTH-1:0] MDRdE;
  logic [1:0]            dbg_state;

  modport master (
    output StartE, MulDivOpE, SrcAE, SrcBE, RdE, FlushE,
    input  StallMD, MDValidE, MDResultE, MDRdE, dbg_state
  );

  modport slave (
    input  StartE, MulDivOpE, SrcAE, SrcBE, RdE, FlushE,
    output StallMD, MDValidE, MDResultE, MDRdE, dbg_state
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per cycle on a shared
// 2*DATA_WIDTH accumulator, with magnitude pre-conditioning and sign fix-up on completion.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave md
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*W-1:0]        acc_q, acc_d;
  logic [W-1:0]          opnd_q, opnd_d;
  logic [2:0]            op_q, op_d;
  logic                  neg_q, neg_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [W-1:0]          result_q, result_d;

  logic           a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf, neg_start;
  logic [W-1:0]   abs_a, abs_b, special_res, q_fix, r_fix, final_res;
  logic [W:0]     mul_sum, trial;
  logic [2*W-1:0] mul_next, div_next, step, prod_fix;

  // Operand conditioning for a new op.
  always_comb begin
    a_signed  = (md.MulDivOpE == 3'b000) || (md.MulDivOpE == 3'b001) || (md.MulDivOpE == 3'b010) ||
                (md.MulDivOpE == 3'b100) || (md.MulDivOpE == 3'b110);
    b_signed  = (md.MulDivOpE == 3'b000) || (md.MulDivOpE == 3'b001) ||
                (md.MulDivOpE == 3'b100) || (md.MulDivOpE == 3'b110);
    a_neg     = a_signed & md.SrcAE[W-1];
    b_neg     = b_signed & md.SrcBE[W-1];
    abs_a     = a_neg ? -md.SrcAE : md.SrcAE;
    abs_b     = b_neg ? -md.SrcBE : md.SrcBE;
    is_div    = md.MulDivOpE[2];
    div_zero  = is_div && (md.SrcBE == '0);
    div_ovf   = is_div && !md.MulDivOpE[0] && (md.SrcAE == {1'b1, {(W-1){1'b0}}}) && (md.SrcBE == '1);
    // Remainder follows the dividend's sign; product and quotient follow the sign product.
    neg_start = (is_div && md.MulDivOpE[1]) ? a_neg : (a_neg ^ b_neg);
    if (div_zero) special_res = md.MulDivOpE[1] ? md.SrcAE : '1;
    else          special_res = md.MulDivOpE[1] ? '0 : md.SrcAE;
  end

  // One iteration of the shared datapath and the completion fix-up.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};
    trial    = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    div_next = trial[W] ? {acc_q[2*W-2:0], 1'b0} : {trial[W-1:0], acc_q[W-2:0], 1'b1};
    step     = op_q[2] ? div_next : mul_next;
    prod_fix = neg_q ? -step : step;
    q_fix    = neg_q ? -step[W-1:0] : step[W-1:0];
    r_fix    = neg_q ? -step[2*W-1:W] : step[2*W-1:W];
    if (op_q[2])              final_res = op_q[1] ? r_fix : q_fix;
    else if (op_q[1:0] == 2'b00) final_res = prod_fix[W-1:0];
    else                      final_res = prod_fix[2*W-1:W];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    if (md.FlushE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md.StartE) begin
            op_d  = md.MulDivOpE;
            rd_d  = md.RdE;
            neg_d = neg_start;
            cnt_d = '0;
            if (div_zero || div_ovf) begin
              result_d = special_res;
              state_d  = S_DONE;
            end else begin
              acc_d   = is_div ? {{W{1'b0}}, abs_a} : {{W{1'b0}}, abs_b};
              opnd_d  = is_div ? abs_b : abs_a;
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_d = step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            result_d = final_res;
            state_d  = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  assign md.StallMD   = ((state_q == S_IDLE) && md.StartE && !md.FlushE) || (state_q == S_BUSY);
  assign md.MDValidE  = (state_q == S_DONE);
  assign md.MDResultE = (state_q == S_DONE) ? result_q : '0;
  assign md.MDRdE     = (state_q == S_DONE) ? rd_q : '0;
  assign md.dbg_state = state_q;
endmodule
